// File: rtl/xor_keystream_streamer.sv
// xor_keystream_streamer: XORs a packet of plaintext bytes with a rolling LFSR key, emitting ciphertext and key.
module xor_keystream_streamer #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       seed,
  input  logic [LEN_W-1:0] pkt_len,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic [7:0]       out_key,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  logic [1:0]   state;
  logic [7:0]   lfsr;
  logic [7:0]   lfsr_nx;
  logic [LEN_W:0] cnt;
  logic [LEN_W:0] len;
  logic         accept;
  logic         out_fire;
  logic         last_byte;
  assign in_ready  = (state == RUN) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign busy      = state != IDLE;
  assign lfsr_nx   = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
  assign last_byte = (cnt + (LEN_W+1)'(1)) == len;
  // A zero pkt_len is widened to 2^LEN_W so the compare needs no special case
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lfsr      <= 8'h01;
      cnt       <= '0;
      len       <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_key   <= 8'h00;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        lfsr  <= seed == 8'h00 ? 8'h01 : seed;
        len   <= pkt_len == '0 ? {1'b1, {LEN_W{1'b0}}} : {1'b0, pkt_len};
        cnt   <= '0;
        state <= RUN;
      end
      if (accept) begin
        out_data  <= in_data ^ lfsr;
        out_key   <= lfsr;
        out_valid <= 1'b1;
        lfsr      <= lfsr_nx;
        cnt       <= cnt + (LEN_W+1)'(1);
        if (last_byte) begin
          out_last <= 1'b1;
          state    <= DRAIN;
        end
      end else if (out_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        if (state == DRAIN) begin
          done  <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_xor_keystream_streamer.sv
// tb_xor_keystream_streamer: randomized checks of the keystream streamer against a packet-level model.
module tb_xor_keystream_streamer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] seed = 8'h00;
  logic [7:0] pkt_len = 8'h00;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b1;
  logic       in_ready, out_valid, out_last, busy, done;
  logic [7:0] out_data, out_key;
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int mode = 0;
  int hold = 0;
  logic [16:0] obs_q[$];
  logic [16:0] exp_q[$];
  logic [7:0]  in_q[$];
  logic        pstall = 1'b0;
  logic [16:0] pval = '0;

  always #5 clk = ~clk;

  xor_keystream_streamer #(.LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .pkt_len(pkt_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_key(out_key), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  // Drives out_ready, collects output handshakes and checks stall stability
  always begin
    @(negedge clk);
    out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : (hold == 0);
    if (hold > 0) hold--;
    #2;
    if (rst_n) begin
      if (pstall) begin
        total++;
        if (!out_valid || {out_last, out_key, out_data} !== pval) begin
          bad++;
          $display("FAIL stall_hold got v=%b %h need v=1 %h", out_valid, {out_last, out_key, out_data}, pval);
        end
      end
      if (out_valid && out_ready) begin
        obs_q.push_back({out_last, out_key, out_data});
        if (mode == 2) hold = 3;
      end
      if (done) done_cnt++;
    end
    pstall = rst_n && out_valid && !out_ready;
    pval = {out_last, out_key, out_data};
  end

  task automatic fill_rand(input int n);
    in_q.delete();
    for (int i = 0; i < n; i++) in_q.push_back(8'($urandom));
  endtask

  // Packet model: key sequence from the seed, last flag on the final byte
  task automatic build(input logic [7:0] sd, input logic [7:0] ln);
    int n;
    logic [7:0] k;
    n = ln == 0 ? 256 : int'(ln);
    k = sd == 0 ? 8'h01 : sd;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'(i == n - 1), k, in_q[i] ^ k});
      k = k[0] ? (k >> 1) ^ 8'hB8 : k >> 1;
    end
  endtask

  task automatic run_packet(input logic [7:0] sd, input logic [7:0] ln, input int md, input bit rv, input bit inject);
    int idx, g, n;
    idx = 0;
    g = 0;
    n = ln == 0 ? 256 : int'(ln);
    obs_q.delete();
    done_cnt = 0;
    mode = md;
    hold = 0;
    start = 1'b1;
    seed = sd;
    pkt_len = ln;
    @(negedge clk);
    start = 1'b0;
    seed = ~sd;
    pkt_len = ln + 8'd3;
    #3;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_start got %b need 1", busy); end
    while (idx < n && g < 5000) begin
      in_valid = rv ? 1'($urandom_range(0, 3) != 0) : 1'b1;
      in_data = in_q[idx];
      start = inject && idx == 1;
      seed = 8'h5A;
      pkt_len = 8'd7;
      #1;
      if (in_valid && in_ready) idx++;
      @(negedge clk);
      #3;
      g++;
    end
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hEE;
    g = 0;
    while (!done && g < 3000) begin
      @(negedge clk);
      #3;
      g++;
    end
    in_valid = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL done_timeout got accepted=%0d need %0d", idx, n);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #3;
    end
    total++;
    if (busy !== 1'b0 || done_cnt != 1) begin
      bad++;
      $display("FAIL done_pulse got busy=%b dones=%0d need busy=0 dones=1", busy, done_cnt);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    total++;
    if ({in_ready, out_valid, out_data, out_key, out_last, busy, done} !== 21'h0) begin
      bad++;
      $display("FAIL reset_state got %h need 0", {in_ready, out_valid, out_data, out_key, out_last, busy, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #3;
    total++;
    if ({in_ready, busy, out_valid} !== 3'b000) begin
      bad++;
      $display("FAIL idle_after_reset got %b need 000", {in_ready, busy, out_valid});
    end
  endtask

  task automatic test_basic;
    logic [16:0] want[3];
    want = '{{1'b0, 8'h01, 8'h01}, {1'b0, 8'hB8, 8'hB8}, {1'b1, 8'h5C, 8'h5C}};
    in_q = '{8'h00, 8'h00, 8'h00};
    run_packet(8'h01, 8'd3, 0, 1'b0, 1'b0);
    total++;
    if (obs_q.size() != 3) begin bad++; $display("FAIL basic_count got %0d need 3", obs_q.size()); end
    else foreach (want[i]) begin
      total++;
      if (obs_q[i] !== want[i]) begin bad++; $display("FAIL basic_byte%0d got %h need %h", i, obs_q[i], want[i]); end
    end
  endtask

  task automatic test_stall;
    in_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    build(8'hA5, 8'd4);
    run_packet(8'hA5, 8'd4, 2, 1'b0, 1'b0);
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL stall_count got %0d need %0d", obs_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      total += 2;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL stall_byte%0d got %h need %h", i, obs_q[i], exp_q[i]); end
      if ((obs_q[i][7:0] ^ obs_q[i][15:8]) !== in_q[i]) begin
        bad++;
        $display("FAIL stall_decrypt%0d got %h need %h", i, obs_q[i][7:0] ^ obs_q[i][15:8], in_q[i]);
      end
    end
  endtask

  task automatic test_zero_seed;
    fill_rand(2);
    build(8'h00, 8'd2);
    run_packet(8'h00, 8'd2, 0, 1'b0, 1'b0);
    total++;
    if (obs_q.size() != 2) begin bad++; $display("FAIL zseed_count got %0d need 2", obs_q.size()); end
    else begin
      total += 2;
      if (obs_q[0][15:8] !== 8'h01) begin bad++; $display("FAIL zseed_key0 got %h need 01", obs_q[0][15:8]); end
      if (obs_q[1] !== exp_q[1]) begin bad++; $display("FAIL zseed_byte1 got %h need %h", obs_q[1], exp_q[1]); end
    end
  endtask

  task automatic test_full_len;
    in_q.delete();
    for (int i = 0; i < 256; i++) in_q.push_back(8'h00);
    build(8'h01, 8'd0);
    run_packet(8'h01, 8'd0, 0, 1'b0, 1'b0);
    total++;
    if (obs_q.size() != 256) begin bad++; $display("FAIL full_count got %0d need 256", obs_q.size()); end
    else begin
      total++;
      if (obs_q[255][15:8] !== 8'h01) begin bad++; $display("FAIL full_period got %h need 01", obs_q[255][15:8]); end
      foreach (exp_q[i]) begin
        total++;
        if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL full_byte%0d got %h need %h", i, obs_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_mid_reset;
    obs_q.delete();
    done_cnt = 0;
    mode = 0;
    start = 1'b1;
    seed = 8'h33;
    pkt_len = 8'd5;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hA1;
    @(negedge clk);
    in_data = 8'hA2;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, out_data, out_key, out_last, busy, done} !== 21'h0) begin
      bad++;
      $display("FAIL midreset_state got %h need 0", {in_ready, out_valid, out_data, out_key, out_last, busy, done});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #3;
    total++;
    if (done_cnt != 0 || obs_q.size() != 1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midreset_abort got dones=%0d outs=%0d v=%b need 0 1 0", done_cnt, obs_q.size(), out_valid);
    end
    in_q = '{8'h05, 8'h06};
    build(8'h01, 8'd2);
    run_packet(8'h01, 8'd2, 0, 1'b0, 1'b0);
    total++;
    if (obs_q.size() != 2) begin bad++; $display("FAIL restart_count got %0d need 2", obs_q.size()); end
    else foreach (exp_q[i]) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL restart_byte%0d got %h need %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_start_ignored;
    fill_rand(6);
    build(8'h3C, 8'd6);
    run_packet(8'h3C, 8'd6, 1, 1'b1, 1'b1);
    total++;
    if (obs_q.size() != 6) begin bad++; $display("FAIL ignore_count got %0d need 6", obs_q.size()); end
    else foreach (exp_q[i]) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL ignore_byte%0d got %h need %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] sd, ln;
    repeat (4) begin
      sd = 8'($urandom);
      ln = 8'($urandom_range(1, 24));
      fill_rand(int'(ln));
      build(sd, ln);
      run_packet(sd, ln, 1, 1'b1, 1'b0);
      total++;
      if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count got %0d need %0d", obs_q.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin
        total++;
        if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_byte%0d got %h need %h", i, obs_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_zero_seed;
    test_full_len;
    test_mid_reset;
    test_start_ignored;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
